board_pixel_scanner: RTL and testbench
======================================

# board_pixel_scanner

Reads the 10x10 game board out of the board store, which the game logic writes, and streams it cell by cell as colour-coded pixels to the display driver over a valid/ready handshake. It overlays a blinking cursor at the player's selected cell. It sits between `battleship_top`'s board state and the video/LED output stage. Per frame, it is the reader counterpart of the board writer.

## Interface
Parameters:
- `GRID_W`, default 10: columns.
- `GRID_H`, default 10: rows.
- `BLINK_FRAMES`, default 16: completed frames per cursor blink phase.

Ports:
- `clk`, in, 1: single clock. Everything is sampled on the rising edge.
- `reset`, in, 1: synchronous, active-high reset.
- `frame_start`, in, 1: one-cycle pulse that requests a full board scan.
- `cursor_x`, in, 4: cursor column. Latched at an accepted `frame_start`.
- `cursor_y`, in, 4: cursor row. Latched at an accepted `frame_start`.
- `cell_addr`, out, 7: board read address, y*GRID_W + x.
- `cell_data`, in, 4: cell state. Valid exactly 1 cycle after `cell_addr` is presented (registered read).
- `pix_valid`, out, 1: pixel available.
- `pix_ready`, in, 1: downstream accepts the pixel.
- `pix_color`, out, 3: colour code.
- `pix_x`, out, 4: pixel column.
- `pix_y`, out, 4: pixel row.
- `pix_last`, out, 1: high on the final pixel of the frame, (GRID_W-1, GRID_H-1).
- `busy`, out, 1: a scan is in progress.

## Operation
- FSM states: IDLE, READ, CAP, OUT.
- IDLE:
  - `frame_start` latches the cursor, clears x/y to 0 and moves to READ.
  - Without `frame_start`, the FSM stays in IDLE.
- READ: drives `cell_addr` = y*GRID_W + x. Moves to CAP.
- CAP: registers `pix_color` (mapped from `cell_data`), `pix_x`/`pix_y` and `pix_last`. Moves to OUT.
- OUT: `pix_valid`=1. The handshake completes on `pix_valid && pix_ready`. On the handshake:
  - If `pix_last`, go to IDLE and increment the frame counter.
  - Otherwise advance x. When x reaches GRID_W-1, wrap x to 0 and increment y. Go to READ.
- Cell-state to colour mapping:
  - EMPTY 0 → WATER 0
  - SHIP 1 → SHIP 1
  - MISS 2 → MISS 2
  - HIT 3 → HIT 3
  - SUNK 4 → SUNK 4
  - Codes 5-15 → ERR 7
- Cursor overlay:
  - Applies when (x, y) equals the latched cursor and `blink_on`=1. It replaces the colour with CURSOR 6.
  - A latched cursor_x ≥ GRID_W or cursor_y ≥ GRID_H disables the overlay for that frame.
- Blink:
  - The frame counter counts completed frames.
  - When it reaches BLINK_FRAMES-1 and another frame completes, the counter wraps to 0 and `blink_on` toggles.
- `busy` = (state != IDLE).

## Timing
- Reset values: state IDLE, `pix_valid` 0, `pix_color` 0, `pix_x` 0, `pix_y` 0, `pix_last` 0, `cell_addr` 0, `busy` 0, frame counter 0, `blink_on` 1.
- Latency:
  - `frame_start` at cycle t: READ at t+1 with `cell_addr`=0, CAP at t+2, first `pix_valid` at t+3.
  - With `pix_ready` held at 1, each pixel takes 3 cycles, so a frame is 300 cycles from the first READ.
  - `busy` falls the cycle after the last handshake.
- `pix_color`, `pix_x`, `pix_y` and `pix_last` are held stable while `pix_valid` && !`pix_ready`.
- `pix_valid` never drops without a handshake.
- `frame_start` while `busy` is ignored. It is not queued, and the cursor is not re-latched.
- A `frame_start` in the same cycle as the final handshake is ignored, because the FSM is not yet in IDLE.
- Cursor inputs may change mid-frame. Only the value latched at `frame_start` is used.
- `reset` mid-frame returns to IDLE next cycle with all reset values, including the blink state.
- `cell_addr` holds its last value outside READ.

## Structure
- Shared package `battleship_pkg` holds:
  - GRID_W/GRID_H constants.
  - The 4-bit cell-state enum (EMPTY, SHIP, MISS, HIT, SUNK). The game logic uses the same enum.
  - The 3-bit colour enum (WATER, SHIP, MISS, HIT, SUNK, CURSOR=6, ERR=7).
- Sub-module `battleship_color_map`: purely combinational mapping from (cell_state, is_cursor, blink_on) to colour. It is instanced once, feeding the CAP register.
- The FSM, x/y counters, cursor latch and blink counter sit in the top of the block.

## Test plan
- Reset, then `frame_start` with `pix_ready`=1 on a board of all EMPTY and the cursor at (2,1).
  - Required: exactly 100 pixels, raster order (0,0)…(9,9), all WATER.
  - The pixel at (2,1), address 12, is CURSOR.
  - `pix_last` is high only on (9,9).
  - The first `pix_valid` arrives 3 cycles after `frame_start`.
- Board with address 23 = HIT, 45 = SUNK, 7 = 9 (invalid).
  - Required: (3,2) is HIT, (5,4) is SUNK, (7,0) is ERR. All other cells are WATER.
- `pix_ready` toggled pseudo-randomly.
  - Required: no pixel is lost or duplicated.
  - The outputs are stable while stalled.
  - 100 handshakes per frame.
- Run 16 frames back-to-back.
  - Required: frames 0-15 show CURSOR at the cursor cell.
  - Frame 16 shows the underlying colour.
  - Frame 32 shows CURSOR again.
- `frame_start` pulsed mid-frame, and the cursor changed mid-frame.
  - Required: the scan continues unaffected using the original cursor, and no extra frame starts.
- Cursor set to (10,3).
  - Required: no CURSOR pixel appears in the frame.
- `reset` asserted at pixel 50.
  - Required: the next cycle shows `pix_valid`=0, `busy`=0.
  - A following `frame_start` restarts at (0,0).

Source files
------------

// File: rtl/battleship_pkg.sv
// -----------------------------------------------------------------------------
// battleship_pkg
//   Types and constants shared by the game logic and the board read-out path.
//   - GRID_W / GRID_H : board dimensions in cells
//   - cell_state_e    : 4-bit per-cell state held in the board store
//   - color_e         : 3-bit colour code sent to the display driver
//   - scan_state_e    : scanner FSM states
// -----------------------------------------------------------------------------
package battleship_pkg;

   localparam int GRID_W = 10;
   localparam int GRID_H = 10;

   // Prefixes keep the cell and colour literals apart (both have a SHIP, etc.).
   typedef enum logic [3:0] {
      CELL_EMPTY = 4'd0,
      CELL_SHIP  = 4'd1,
      CELL_MISS  = 4'd2,
      CELL_HIT   = 4'd3,
      CELL_SUNK  = 4'd4
   } cell_state_e;

   typedef enum logic [2:0] {
      COL_WATER  = 3'd0,
      COL_SHIP   = 3'd1,
      COL_MISS   = 3'd2,
      COL_HIT    = 3'd3,
      COL_SUNK   = 3'd4,
      COL_CURSOR = 3'd6,
      COL_ERR    = 3'd7
   } color_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_READ = 2'd1,
      ST_CAP  = 2'd2,
      ST_OUT  = 2'd3
   } scan_state_e;

endpackage

// File: rtl/battleship_color_map.sv
// -----------------------------------------------------------------------------
// battleship_color_map
//   Combinational translation of a board cell into a display colour, with the
//   blinking cursor taking priority over the cell contents.
//   Ports:
//     cell_state_i : raw 4-bit cell state from the board store
//     is_cursor_i  : this cell is the (valid) latched cursor position
//     blink_on_i   : cursor is in its visible blink phase
//     color_o      : 3-bit colour code
// -----------------------------------------------------------------------------
module battleship_color_map
   import battleship_pkg::*;
(
   input  logic [3:0] cell_state_i,
   input  logic       is_cursor_i,
   input  logic       blink_on_i,
   output logic [2:0] color_o
);

   always_comb begin
      color_o = COL_ERR;
      if (is_cursor_i && blink_on_i) begin
         color_o = COL_CURSOR;
      end else begin
         case (cell_state_i)
            CELL_EMPTY: color_o = COL_WATER;
            CELL_SHIP:  color_o = COL_SHIP;
            CELL_MISS:  color_o = COL_MISS;
            CELL_HIT:   color_o = COL_HIT;
            CELL_SUNK:  color_o = COL_SUNK;
            // Codes 5..15 are not legal cell states; flag them visibly.
            default:    color_o = COL_ERR;
         endcase
      end
   end

endmodule

// File: rtl/board_pixel_scanner.sv
// -----------------------------------------------------------------------------
// board_pixel_scanner
//   Scans the GRID_W x GRID_H board store in raster order once per frame_start
//   and streams each cell as a coloured pixel over a valid/ready handshake,
//   overlaying a blinking cursor at the position latched at frame start.
//   Ports:
//     clk, reset           : clock, synchronous active-high reset
//     frame_start          : one-cycle scan request (ignored while busy)
//     cursor_x, cursor_y   : cursor position, latched on an accepted start
//     cell_addr            : board read address y*GRID_W + x (registered)
//     cell_data            : board read data, valid one cycle after cell_addr
//     pix_valid, pix_ready : pixel handshake
//     pix_color            : colour code of the pixel
//     pix_x, pix_y         : pixel coordinates
//     pix_last             : final pixel of the frame
//     busy                 : scan in progress
// -----------------------------------------------------------------------------
module board_pixel_scanner #(
   parameter int GRID_W       = battleship_pkg::GRID_W,
   parameter int GRID_H       = battleship_pkg::GRID_H,
   parameter int BLINK_FRAMES = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       frame_start,
   input  logic [3:0] cursor_x,
   input  logic [3:0] cursor_y,
   output logic [6:0] cell_addr,
   input  logic [3:0] cell_data,
   output logic       pix_valid,
   input  logic       pix_ready,
   output logic [2:0] pix_color,
   output logic [3:0] pix_x,
   output logic [3:0] pix_y,
   output logic       pix_last,
   output logic       busy
);

   import battleship_pkg::*;

   localparam int               CNT_W   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [3:0]       X_MAX   = 4'(GRID_W - 1);
   localparam logic [3:0]       Y_MAX   = 4'(GRID_H - 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLINK_FRAMES - 1);

   function automatic logic [6:0] addr_of(input logic [3:0] x, input logic [3:0] y);
      return 7'(int'(y) * GRID_W + int'(x));
   endfunction

   scan_state_e      state_q,     state_d;
   logic [3:0]       x_q,         x_d;
   logic [3:0]       y_q,         y_d;
   logic [3:0]       cur_x_q,     cur_x_d;
   logic [3:0]       cur_y_q,     cur_y_d;
   logic             cur_en_q,    cur_en_d;
   logic [6:0]       addr_q,      addr_d;
   logic [2:0]       color_q,     color_d;
   logic [3:0]       px_q,        px_d;
   logic [3:0]       py_q,        py_d;
   logic             last_q,      last_d;
   logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
   logic             blink_q,     blink_d;

   logic             is_cursor;
   logic [2:0]       mapped_color;
   logic [3:0]       x_nxt;
   logic [3:0]       y_nxt;

   // An out-of-range latched cursor never matches, so the overlay is off for
   // the whole frame.
   assign is_cursor = cur_en_q && (x_q == cur_x_q) && (y_q == cur_y_q);

   battleship_color_map u_color_map (
      .cell_state_i (cell_data),
      .is_cursor_i  (is_cursor),
      .blink_on_i   (blink_q),
      .color_o      (mapped_color)
   );

   // Raster advance used on a non-final handshake.
   always_comb begin
      x_nxt = x_q + 4'd1;
      y_nxt = y_q;
      if (x_q == X_MAX) begin
         x_nxt = 4'd0;
         y_nxt = y_q + 4'd1;
      end
   end

   always_comb begin
      state_d     = state_q;
      x_d         = x_q;
      y_d         = y_q;
      cur_x_d     = cur_x_q;
      cur_y_d     = cur_y_q;
      cur_en_d    = cur_en_q;
      addr_d      = addr_q;
      color_d     = color_q;
      px_d        = px_q;
      py_d        = py_q;
      last_d      = last_q;
      frame_cnt_d = frame_cnt_q;
      blink_d     = blink_q;

      case (state_q)
         ST_IDLE: begin
            if (frame_start) begin
               cur_x_d  = cursor_x;
               cur_y_d  = cursor_y;
               cur_en_d = (int'(cursor_x) < GRID_W) && (int'(cursor_y) < GRID_H);
               x_d      = 4'd0;
               y_d      = 4'd0;
               addr_d   = 7'd0;
               state_d  = ST_READ;
            end
         end

         // Address is already presented; the store registers it this cycle.
         ST_READ: begin
            state_d = ST_CAP;
         end

         // cell_data is valid now; capture the finished pixel.
         ST_CAP: begin
            color_d = mapped_color;
            px_d    = x_q;
            py_d    = y_q;
            last_d  = (x_q == X_MAX) && (y_q == Y_MAX);
            state_d = ST_OUT;
         end

         ST_OUT: begin
            if (pix_ready) begin
               if (last_q) begin
                  state_d = ST_IDLE;
                  if (frame_cnt_q == CNT_MAX) begin
                     frame_cnt_d = '0;
                     blink_d     = ~blink_q;
                  end else begin
                     frame_cnt_d = frame_cnt_q + CNT_W'(1);
                  end
               end else begin
                  x_d     = x_nxt;
                  y_d     = y_nxt;
                  addr_d  = addr_of(x_nxt, y_nxt);
                  state_d = ST_READ;
               end
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         x_q         <= 4'd0;
         y_q         <= 4'd0;
         cur_x_q     <= 4'd0;
         cur_y_q     <= 4'd0;
         cur_en_q    <= 1'b0;
         addr_q      <= 7'd0;
         color_q     <= 3'd0;
         px_q        <= 4'd0;
         py_q        <= 4'd0;
         last_q      <= 1'b0;
         frame_cnt_q <= '0;
         blink_q     <= 1'b1;
      end else begin
         state_q     <= state_d;
         x_q         <= x_d;
         y_q         <= y_d;
         cur_x_q     <= cur_x_d;
         cur_y_q     <= cur_y_d;
         cur_en_q    <= cur_en_d;
         addr_q      <= addr_d;
         color_q     <= color_d;
         px_q        <= px_d;
         py_q        <= py_d;
         last_q      <= last_d;
         frame_cnt_q <= frame_cnt_d;
         blink_q     <= blink_d;
      end
   end

   assign cell_addr = addr_q;
   assign pix_valid = (state_q == ST_OUT);
   assign pix_color = color_q;
   assign pix_x     = px_q;
   assign pix_y     = py_q;
   assign pix_last  = last_q;
   assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_board_pixel_scanner.sv
// -----------------------------------------------------------------------------
// tb_board_pixel_scanner
//   Directed frame scans against a board-store model. Expected pixels come from
//   the board contents, the cursor given at frame start and the number of
//   frames completed since reset.
// -----------------------------------------------------------------------------
module tb_board_pixel_scanner;

   localparam int W     = 10;
   localparam int H     = 10;
   localparam int BLINK = 16;

   logic       clk = 1'b0;
   logic       reset;
   logic       frame_start;
   logic [3:0] cursor_x;
   logic [3:0] cursor_y;
   logic [6:0] cell_addr;
   logic [3:0] cell_data = 4'd0;
   logic       pix_valid;
   logic       pix_ready;
   logic [2:0] pix_color;
   logic [3:0] pix_x;
   logic [3:0] pix_y;
   logic       pix_last;
   logic       busy;

   logic [3:0] mem [0:127];

   int total = 0;
   int bad   = 0;
   int frames_done = 0;

   board_pixel_scanner #(.GRID_W(W), .GRID_H(H), .BLINK_FRAMES(BLINK)) dut (
      .clk         (clk),
      .reset       (reset),
      .frame_start (frame_start),
      .cursor_x    (cursor_x),
      .cursor_y    (cursor_y),
      .cell_addr   (cell_addr),
      .cell_data   (cell_data),
      .pix_valid   (pix_valid),
      .pix_ready   (pix_ready),
      .pix_color   (pix_color),
      .pix_x       (pix_x),
      .pix_y       (pix_y),
      .pix_last    (pix_last),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   // Board store with one-cycle registered read.
   always @(posedge clk) cell_data <= mem[cell_addr];

   task automatic check(input string tag, input int got, input int exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
      end
   endtask

   function automatic int model_color(input int idx, input int cx, input int cy, input bit blink);
      int c;
      c = int'(mem[idx]);
      if (blink && cx < W && cy < H && idx == cy * W + cx) return 6;
      if (c <= 4) return c;
      return 7;
   endfunction

   task automatic clear_board();
      for (int i = 0; i < 128; i++) mem[i] = 4'd0;
   endtask

   // Entered and left half a cycle after... precisely #1 after a rising edge.
   task automatic do_frame(input int cx, input int cy, input int pct,
                           input bit chk_lat, input bit disturb, input int abort_at);
      int  exp_col [100];
      bit  blink;
      int  n = 0;
      int  cyc = 0;
      int  first_v = -1;
      bit  did_pulse = 0;
      bit  rdy;
      bit  pv_prev = 0;
      bit  rdy_prev = 0;
      int  col_prev = 0, x_prev = 0, y_prev = 0, last_prev = 0;

      blink = ((frames_done / BLINK) % 2) == 0;
      for (int i = 0; i < 100; i++) exp_col[i] = model_color(i, cx, cy, blink);

      cursor_x    = 4'(cx);
      cursor_y    = 4'(cy);
      frame_start = 1'b1;
      @(posedge clk); #1;
      frame_start = 1'b0;
      if (chk_lat) begin
         check("lat_busy", int'(busy), 1);
         check("lat_valid0", int'(pix_valid), 0);
         check("lat_addr0", int'(cell_addr), 0);
      end

      while (n < 100 && cyc < 4000) begin
         frame_start = 1'b0;
         if (abort_at >= 0 && n == abort_at) begin
            pix_ready = 1'b0;
            reset     = 1'b1;
            @(posedge clk); #1;
            check("rst_valid", int'(pix_valid), 0);
            check("rst_busy", int'(busy), 0);
            check("rst_addr", int'(cell_addr), 0);
            check("rst_last", int'(pix_last), 0);
            reset = 1'b0;
            frames_done = 0;
            return;
         end
         if (pv_prev && !rdy_prev) begin
            check("stall_valid", int'(pix_valid), 1);
            check("stall_color", int'(pix_color), col_prev);
            check("stall_x", int'(pix_x), x_prev);
            check("stall_y", int'(pix_y), y_prev);
            check("stall_last", int'(pix_last), last_prev);
         end
         if (pix_valid && first_v < 0) first_v = cyc;
         if (disturb && n == 40 && !did_pulse) begin
            frame_start = 1'b1;
            cursor_x    = 4'd0;
            cursor_y    = 4'd0;
            did_pulse   = 1'b1;
         end
         rdy = ($urandom_range(99) < pct);
         pix_ready = rdy;
         if (pix_valid && rdy) begin
            check("pix_x", int'(pix_x), n % W);
            check("pix_y", int'(pix_y), n / W);
            check("pix_last", int'(pix_last), (n == 99) ? 1 : 0);
            check("pix_color", int'(pix_color), exp_col[n]);
            if (disturb && n == 99) frame_start = 1'b1;
            n++;
         end
         pv_prev   = pix_valid;
         rdy_prev  = rdy;
         col_prev  = int'(pix_color);
         x_prev    = int'(pix_x);
         y_prev    = int'(pix_y);
         last_prev = int'(pix_last);
         @(posedge clk); #1;
         cyc++;
      end
      frame_start = 1'b0;
      pix_ready   = 1'b0;

      check("handshakes", n, 100);
      check("busy_after", int'(busy), 0);
      check("valid_after", int'(pix_valid), 0);
      if (chk_lat) begin
         check("first_valid_cyc", first_v, 2);
         if (pct == 100) check("frame_cycles", cyc, 300);
      end
      if (disturb) begin
         for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check("no_extra_frame", int'(busy), 0);
         end
      end
      frames_done++;
   endtask

   initial begin
      reset       = 1'b1;
      frame_start = 1'b0;
      pix_ready   = 1'b0;
      cursor_x    = 4'd0;
      cursor_y    = 4'd0;
      clear_board();
      repeat (3) @(posedge clk);
      #1;
      check("reset_valid", int'(pix_valid), 0);
      check("reset_busy", int'(busy), 0);
      check("reset_addr", int'(cell_addr), 0);
      check("reset_color", int'(pix_color), 0);
      check("reset_x", int'(pix_x), 0);
      check("reset_y", int'(pix_y), 0);
      check("reset_last", int'(pix_last), 0);
      reset = 1'b0;
      @(posedge clk); #1;

      // Empty board, cursor (2,1), ready held high, latency checked.
      do_frame(2, 1, 100, 1'b1, 1'b0, -1);

      // Sparse board, cursor off the board so no overlay appears.
      mem[23] = 4'd3;
      mem[45] = 4'd4;
      mem[7]  = 4'd9;
      do_frame(10, 3, 100, 1'b0, 1'b0, -1);

      // Random board, random cursor, random back-pressure.
      for (int i = 0; i < 100; i++) mem[i] = 4'($urandom_range(15));
      do_frame(int'($urandom_range(9)), int'($urandom_range(9)), 50, 1'b0, 1'b0, -1);

      // Mid-frame start pulse and cursor change, plus a start on the final handshake.
      do_frame(4, 4, 70, 1'b0, 1'b1, -1);

      // Back-to-back frames through two blink phase changes (frames 16 and 32).
      while (frames_done < 33) do_frame(5, 5, 100, 1'b0, 1'b0, -1);

      // Reset in the middle of a frame, then a clean restart from (0,0).
      do_frame(3, 3, 100, 1'b0, 1'b0, 50);
      do_frame(3, 3, 80, 1'b1, 1'b0, -1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
